// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI burst RAM: opcodes, FSM states and the
// wrapping pointer increment used by both the write and read pointers.
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_TURN,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    // Wraps at depth-1 so non-power-of-two memories stay in range.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM: a write or a registered read on each edge.
// Contents are deliberately not reset.
module spi_ram_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end else begin
            dout <= r_mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI slave with an embedded RAM: address loads, burst writes and streaming
// reads inside one SS_n frame, clocked directly by the SPI serial clock.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] wr_ptr_o,
    output logic [ADDR_WIDTH-1:0] rd_ptr_o
);

    localparam int SHIFT_W = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int CNT_W   = $clog2(SHIFT_W);

    state_t                r_state;
    logic                  r_op_hi;
    logic [SHIFT_W-2:0]    r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic                  r_miso;
    logic                  r_busy;

    logic [SHIFT_W-1:0]    w_shift_nx;
    logic [ADDR_WIDTH-1:0] w_addr_mod;
    logic [ADDR_WIDTH-1:0] w_wr_inc;
    logic [ADDR_WIDTH-1:0] w_rd_inc;
    logic [ADDR_WIDTH-1:0] w_rd_inc2;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_addr_last;
    logic                  w_data_last;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_mem_dout;

    function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] p);
        return ADDR_WIDTH'(ptr_inc(32'(p), DEPTH));
    endfunction

    assign w_shift_nx  = {r_shift, MOSI};
    assign w_addr_mod  = ADDR_WIDTH'({1'b0, w_shift_nx[ADDR_WIDTH-1:0]} % (ADDR_WIDTH + 1)'(DEPTH));
    assign w_wr_inc    = inc(r_wr_ptr);
    assign w_rd_inc    = inc(r_rd_ptr);
    assign w_rd_inc2   = inc(w_rd_inc);
    assign w_addr_last = (r_cnt == CNT_W'(ADDR_WIDTH - 1));
    assign w_data_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));
    assign w_mem_we    = (r_state == ST_WR_DATA) && !SS_n && w_data_last;

    // The RAM output is registered, so reads run one word ahead: the CMD edge
    // fetches mem[rd_ptr] for RD_TURN, and in RD_DATA the port already holds the
    // next word when the LSB edge reloads the tx register.
    always_comb begin
        w_mem_addr = r_rd_ptr;
        if (r_state == ST_WR_DATA) begin
            w_mem_addr = r_wr_ptr;
        end else if (r_state == ST_RD_TURN) begin
            w_mem_addr = w_rd_inc;
        end else if (r_state == ST_RD_DATA) begin
            w_mem_addr = w_data_last ? w_rd_inc2 : w_rd_inc;
        end
    end

    spi_ram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (w_mem_we),
        .addr (w_mem_addr),
        .din  (w_shift_nx[DATA_WIDTH-1:0]),
        .dout (w_mem_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op_hi  <= 1'b0;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_tx     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_miso   <= 1'b0;
            r_busy   <= 1'b0;
        end else if (SS_n) begin
            // Deselect drops any partial field; pointers only move on complete fields.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_miso  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_miso <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_op_hi <= MOSI;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= ST_CMD;
                end
                ST_CMD: begin
                    r_cnt <= '0;
                    case ({r_op_hi, MOSI})
                        OP_WR_ADDR: r_state <= ST_WR_ADDR;
                        OP_WR_DATA: r_state <= ST_WR_DATA;
                        OP_RD_ADDR: r_state <= ST_RD_ADDR;
                        default:    r_state <= ST_RD_TURN;
                    endcase
                end
                ST_WR_ADDR, ST_RD_ADDR: begin
                    r_shift <= w_shift_nx[SHIFT_W-2:0];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_addr_last) begin
                        if (r_state == ST_WR_ADDR) begin
                            r_wr_ptr <= w_addr_mod;
                        end else begin
                            r_rd_ptr <= w_addr_mod;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_WR_DATA: begin
                    r_shift <= w_shift_nx[SHIFT_W-2:0];
                    if (w_data_last) begin
                        r_cnt <= '0;
                        if (AUTO_INC) begin
                            r_wr_ptr <= w_wr_inc;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RD_TURN: begin
                    r_tx    <= w_mem_dout;
                    r_cnt   <= '0;
                    r_state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    r_miso <= r_tx[DATA_WIDTH-1];
                    if (w_data_last) begin
                        r_cnt <= '0;
                        if (AUTO_INC) begin
                            r_rd_ptr <= w_rd_inc;
                            r_tx     <= w_mem_dout;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_tx  <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                    r_state <= ST_DONE;
                end
            endcase
        end
    end

    assign MISO     = r_miso;
    assign busy     = r_busy;
    assign wr_ptr_o = r_wr_ptr;
    assign rd_ptr_o = r_rd_ptr;

endmodule
